// File: rtl/rb_sb.sv
// Parametrised register bank: one write port, NRP combinational read ports,
// optional write bypass, optional zero register, pending scoreboard and sequenced clear.
module rb_sb #(
    parameter int DW      = 16,
    parameter int NREG    = 8,
    parameter int NRP     = 2,
    parameter int BYPASS  = 1,
    parameter int R0_ZERO = 0,
    localparam int AW     = $clog2(NREG)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we_in,
    input  logic [AW-1:0]            wa_in,
    input  logic [DW-1:0]            d_in,
    input  logic                     res_in,
    input  logic [AW-1:0]            resa_in,
    input  logic [NRP-1:0][AW-1:0]   ra_in,
    output logic [NRP-1:0][DW-1:0]   rd_out,
    output logic [NRP-1:0]           pend_out,
    input  logic                     clr_in,
    output logic                     busy_out,
    output logic                     drop_out
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [AW:0]   NREG_A = (AW+1)'(NREG);
    localparam logic [AW-1:0] LAST   = AW'(NREG - 1);

    state_t          state_reg, state_next;
    logic [AW-1:0]   cnt_reg, cnt_next;
    logic [DW-1:0]   mem_reg [NREG];
    logic [NREG-1:0] pend_reg;
    logic            wr_ok, res_ok;

    // Address is backed by a real, writable register (excludes the zero register).
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < NREG_A) && !((R0_ZERO != 0) && (a == '0));
    endfunction

    assign wr_ok    = (state_reg == IDLE) && we_in  && addr_ok(wa_in);
    assign res_ok   = (state_reg == IDLE) && res_in && addr_ok(resa_in);
    assign busy_out = (state_reg == CLEAR);
    assign drop_out = (state_reg == CLEAR) && (we_in || res_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (clr_in) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            CLEAR: begin
                cnt_next = cnt_reg + AW'(1);
                if (cnt_reg == LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Reserve overrides a same-cycle write's pending clear; a clear request
    // lets the write land but wipes every pending bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) mem_reg[i] <= '0;
            pend_reg <= '0;
        end else if (state_reg == CLEAR) begin
            for (int i = 0; i < NREG; i++)
                if (cnt_reg == AW'(i)) mem_reg[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wr_ok && (wa_in == AW'(i))) mem_reg[i] <= d_in;
                if (clr_in)
                    pend_reg[i] <= 1'b0;
                else if (res_ok && (resa_in == AW'(i)))
                    pend_reg[i] <= 1'b1;
                else if (wr_ok && (wa_in == AW'(i)))
                    pend_reg[i] <= 1'b0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NRP; gi++) begin : g_rd
            logic hit, byp;
            assign hit          = addr_ok(ra_in[gi]);
            assign byp          = (BYPASS != 0) && wr_ok && (wa_in == ra_in[gi]);
            assign rd_out[gi]   = !hit ? '0 : (byp ? d_in : mem_reg[ra_in[gi]]);
            assign pend_out[gi] = hit && pend_reg[ra_in[gi]];
        end
    endgenerate

endmodule

// File: tb/tb_rb_sb.sv
// Bench for rb_sb: three configurations share one stimulus stream; expected
// read data is queued when stimulus is driven and popped when sampled.
module tb_rb_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, we, res, clr;
    logic [2:0]       wa, resa;
    logic [15:0]      d;
    logic [1:0][2:0]  ra;
    logic [1:0][15:0] rd_a, rd_b, rd_c;
    logic [1:0]       pend_a, pend_b, pend_c;
    logic             busy_a, busy_b, busy_c, drop_a, drop_b, drop_c;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [15:0] val;
    } exp_t;
    exp_t exp_q[$];

    rb_sb #(.DW(16), .NREG(8), .NRP(2), .BYPASS(1), .R0_ZERO(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .we_in(we), .wa_in(wa), .d_in(d),
        .res_in(res), .resa_in(resa), .ra_in(ra), .rd_out(rd_a),
        .pend_out(pend_a), .clr_in(clr), .busy_out(busy_a), .drop_out(drop_a)
    );
    rb_sb #(.DW(16), .NREG(8), .NRP(2), .BYPASS(0), .R0_ZERO(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .we_in(we), .wa_in(wa), .d_in(d),
        .res_in(res), .resa_in(resa), .ra_in(ra), .rd_out(rd_b),
        .pend_out(pend_b), .clr_in(clr), .busy_out(busy_b), .drop_out(drop_b)
    );
    rb_sb #(.DW(16), .NREG(6), .NRP(2), .BYPASS(1), .R0_ZERO(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .we_in(we), .wa_in(wa), .d_in(d),
        .res_in(res), .resa_in(resa), .ra_in(ra), .rd_out(rd_c),
        .pend_out(pend_c), .clr_in(clr), .busy_out(busy_c), .drop_out(drop_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        we  = 1'b0;
        res = 1'b0;
        clr = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        idle_in();
        wa = '0; resa = '0; d = '0;
        ra[0] = 3'd3; ra[1] = 3'd7;
        exp_q.push_back('{"rst_rd0", 16'h0000});
        exp_q.push_back('{"rst_rd1", 16'h0000});
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (rd_a[0] !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, rd_a[0], e.val); end
        e = exp_q.pop_front(); checks++;
        if (rd_a[1] !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, rd_a[1], e.val); end
        checks++;
        if (pend_a !== 2'b00) begin errors++; $display("FAIL rst_pend got %b expected 00", pend_a); end
        checks++;
        if ({busy_a, drop_a} !== 2'b00) begin errors++; $display("FAIL rst_busy_drop got %b expected 00", {busy_a, drop_a}); end
        tick();
        rst_n = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_write_read();
        exp_t e;
        we = 1'b1; wa = 3'd3; d = 16'hBEEF;
        ra[0] = 3'd3; ra[1] = 3'd3;
        tick();
        idle_in();
        exp_q.push_back('{"wr_a_p0", 16'hBEEF});
        exp_q.push_back('{"wr_a_p1", 16'hBEEF});
        exp_q.push_back('{"wr_b_p0", 16'hBEEF});
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (rd_a[0] !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, rd_a[0], e.val); end
        e = exp_q.pop_front(); checks++;
        if (rd_a[1] !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, rd_a[1], e.val); end
        e = exp_q.pop_front(); checks++;
        if (rd_b[0] !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, rd_b[0], e.val); end
        checks++;
        if (pend_a !== 2'b00) begin errors++; $display("FAIL wr_pend got %b expected 00", pend_a); end
        tick();
        $display("test_write_read done");
    endtask

    task automatic test_bypass();
        exp_t e;
        we = 1'b1; wa = 3'd5; d = 16'h1234;
        ra[0] = 3'd5; ra[1] = 3'd3;
        exp_q.push_back('{"byp_a", 16'h1234});
        exp_q.push_back('{"byp_b_old", 16'h0000});
        exp_q.push_back('{"byp_c", 16'h1234});
        exp_q.push_back('{"byp_a_other", 16'hBEEF});
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (rd_a[0] !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, rd_a[0], e.val); end
        e = exp_q.pop_front(); checks++;
        if (rd_b[0] !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, rd_b[0], e.val); end
        e = exp_q.pop_front(); checks++;
        if (rd_c[0] !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, rd_c[0], e.val); end
        e = exp_q.pop_front(); checks++;
        if (rd_a[1] !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, rd_a[1], e.val); end
        tick();
        idle_in();
        exp_q.push_back('{"byp_b_next", 16'h1234});
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (rd_b[0] !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, rd_b[0], e.val); end
        tick();
        $display("test_bypass done");
    endtask

    task automatic test_reserve();
        exp_t e;
        res = 1'b1; resa = 3'd2; ra[0] = 3'd2;
        @(negedge clk);
        checks++;
        if (pend_a[0] !== 1'b0) begin errors++; $display("FAIL rsv_same_cycle got %b expected 0", pend_a[0]); end
        tick();
        res = 1'b0;
        @(negedge clk);
        checks++;
        if (pend_a[0] !== 1'b1) begin errors++; $display("FAIL rsv_set got %b expected 1", pend_a[0]); end
        tick();
        we = 1'b1; wa = 3'd2; d = 16'hAAAA; res = 1'b1; resa = 3'd2;
        tick();
        idle_in();
        exp_q.push_back('{"rsv_wr_data", 16'hAAAA});
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (rd_a[0] !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, rd_a[0], e.val); end
        checks++;
        if (pend_a[0] !== 1'b1) begin errors++; $display("FAIL rsv_wins got %b expected 1", pend_a[0]); end
        tick();
        we = 1'b1; wa = 3'd2; d = 16'h5555;
        tick();
        idle_in();
        exp_q.push_back('{"rsv_wr_only", 16'h5555});
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (rd_a[0] !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, rd_a[0], e.val); end
        checks++;
        if (pend_a[0] !== 1'b0) begin errors++; $display("FAIL rsv_cleared got %b expected 0", pend_a[0]); end
        tick();
        $display("test_reserve done");
    endtask

    task automatic test_r0_nreg();
        exp_t e;
        we = 1'b1; wa = 3'd0; d = 16'hFFFF; ra[0] = 3'd0;
        exp_q.push_back('{"c_r0_nobyp", 16'h0000});
        exp_q.push_back('{"a_r0_byp", 16'hFFFF});
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (rd_c[0] !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, rd_c[0], e.val); end
        e = exp_q.pop_front(); checks++;
        if (rd_a[0] !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, rd_a[0], e.val); end
        tick();
        we = 1'b1; wa = 3'd7; d = 16'hABCD; res = 1'b1; resa = 3'd0;
        ra[0] = 3'd0; ra[1] = 3'd7;
        exp_q.push_back('{"c_oor_nobyp", 16'h0000});
        @(negedge clk);
        checks++;
        if (drop_c !== 1'b0) begin errors++; $display("FAIL c_oor_drop got %b expected 0", drop_c); end
        e = exp_q.pop_front(); checks++;
        if (rd_c[1] !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, rd_c[1], e.val); end
        tick();
        idle_in();
        exp_q.push_back('{"c_r0_read", 16'h0000});
        exp_q.push_back('{"c_oor_read", 16'h0000});
        exp_q.push_back('{"a_r0_read", 16'hFFFF});
        exp_q.push_back('{"a_r7_read", 16'hABCD});
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (rd_c[0] !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, rd_c[0], e.val); end
        e = exp_q.pop_front(); checks++;
        if (rd_c[1] !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, rd_c[1], e.val); end
        e = exp_q.pop_front(); checks++;
        if (rd_a[0] !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, rd_a[0], e.val); end
        e = exp_q.pop_front(); checks++;
        if (rd_a[1] !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, rd_a[1], e.val); end
        checks++;
        if (pend_c !== 2'b00) begin errors++; $display("FAIL c_pend got %b expected 00", pend_c); end
        checks++;
        if (pend_a[0] !== 1'b1) begin errors++; $display("FAIL a_r0_pend got %b expected 1", pend_a[0]); end
        tick();
        $display("test_r0_nreg done");
    endtask

    task automatic test_clear();
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            we = 1'b1; wa = 3'(i); d = 16'((i + 1) * 16'h11);
            tick();
        end
        we = 1'b0; res = 1'b1; resa = 3'd4; clr = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b0) begin errors++; $display("FAIL clr_busy_early got %b expected 0", busy_a); end
        tick();
        idle_in();
        for (int k = 0; k < 8; k++) begin
            ra[0] = 3'(k);
            ra[1] = (k == 0) ? 3'd7 : 3'(k - 1);
            we = (k == 3); wa = 3'(k); d = 16'hFFFF;
            exp_q.push_back('{"clr_intact", 16'((k + 1) * 16'h11)});
            exp_q.push_back('{"clr_swept", (k == 0) ? 16'h0088 : 16'h0000});
            @(negedge clk);
            checks++;
            if (busy_a !== 1'b1) begin errors++; $display("FAIL clr_busy k=%0d got %b expected 1", k, busy_a); end
            checks++;
            if (drop_a !== (k == 3)) begin errors++; $display("FAIL clr_drop k=%0d got %b expected %b", k, drop_a, (k == 3)); end
            e = exp_q.pop_front(); checks++;
            if (rd_a[0] !== e.val) begin errors++; $display("FAIL %s k=%0d got %h expected %h", e.name, k, rd_a[0], e.val); end
            e = exp_q.pop_front(); checks++;
            if (rd_a[1] !== e.val) begin errors++; $display("FAIL %s k=%0d got %h expected %h", e.name, k, rd_a[1], e.val); end
            tick();
        end
        idle_in();
        for (int i = 0; i < 8; i++) begin
            ra[0] = 3'(i); ra[1] = 3'd4;
            exp_q.push_back('{"clr_after", 16'h0000});
            @(negedge clk);
            e = exp_q.pop_front(); checks++;
            if (rd_a[0] !== e.val) begin errors++; $display("FAIL %s r%0d got %h expected %h", e.name, i, rd_a[0], e.val); end
            if (i == 0) begin
                checks++;
                if (busy_a !== 1'b0) begin errors++; $display("FAIL clr_busy_end got %b expected 0", busy_a); end
                checks++;
                if (pend_a[1] !== 1'b0) begin errors++; $display("FAIL clr_pend got %b expected 0", pend_a[1]); end
            end
            tick();
        end
        $display("test_clear done");
    endtask

    task automatic test_back_to_back();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int k = 0; k < 8; k++) begin
            clr = (k == 7);
            @(negedge clk);
            checks++;
            if (busy_a !== 1'b1) begin errors++; $display("FAIL b2b_busy k=%0d got %b expected 1", k, busy_a); end
            tick();
        end
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b0) begin errors++; $display("FAIL b2b_ignored got %b expected 0", busy_a); end
        tick();
        clr = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b1) begin errors++; $display("FAIL b2b_accepted got %b expected 1", busy_a); end
        for (int k = 0; k < 8; k++) tick();
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b0) begin errors++; $display("FAIL b2b_done got %b expected 0", busy_a); end
        tick();
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid_clear();
        exp_t e;
        we = 1'b1; wa = 3'd6; d = 16'h6666;
        tick();
        we = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        ra[0] = 3'd6; ra[1] = 3'd1;
        rst_n = 1'b0;
        exp_q.push_back('{"rstclr_r6", 16'h0000});
        #1;
        checks++;
        if (busy_a !== 1'b0) begin errors++; $display("FAIL rstclr_busy got %b expected 0", busy_a); end
        e = exp_q.pop_front(); checks++;
        if (rd_a[0] !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, rd_a[0], e.val); end
        tick();
        rst_n = 1'b1;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b1) begin errors++; $display("FAIL rstclr_reaccept got %b expected 1", busy_a); end
        for (int k = 0; k < 9; k++) tick();
        $display("test_reset_mid_clear done");
    endtask

    initial begin
        rst_n = 1'b0;
        we = 1'b0; res = 1'b0; clr = 1'b0;
        wa = '0; resa = '0; d = '0; ra = '0;
        test_reset();
        test_write_read();
        test_bypass();
        test_reserve();
        test_r0_nreg();
        test_clear();
        test_back_to_back();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
